// File: rtl/step_sequencer_arb.sv
// step_sequencer_arb: runs the round/step schedule for a set of step units that
// share one state-memory port. Each round starts the enabled units in ascending
// index order, one at a time, and waits for the active unit's done. While a unit
// is active, its memory request is routed combinationally to the shared port.
//
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   go, step_mask         run request (sampled in idle) and unit enable mask
//   busy, finished        run in progress / one-cycle completion pulse
//   turn, last_round      current round index / turn == ROUNDS-1
//   step_start, step_done one-hot start to the active unit / per-unit done
//   u_adr, u_in, u_r, u_w per-unit memory requests (unit k at slice k)
//   mem_adr, mem_in,
//   mem_r, mem_w          shared memory port
//   error                 sticky watchdog flag
//
// Optional feature: define STEP_SEQ_WATCHDOG_EN to abort a step that does not
// report done within TIMEOUT cycles; otherwise error is tied low.
module step_sequencer_arb #(
  parameter int NUM_STEPS = 5,
  parameter int ADR_W     = 6,
  parameter int DATA_W    = 25,
  parameter int ROUNDS    = 24,
  parameter int TURN_W    = 5,
  parameter int TIMEOUT   = 255
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        go,
  input  logic [NUM_STEPS-1:0]        step_mask,
  output logic                        busy,
  output logic                        finished,
  output logic [TURN_W-1:0]           turn,
  output logic                        last_round,
  output logic [NUM_STEPS-1:0]        step_start,
  input  logic [NUM_STEPS-1:0]        step_done,
  input  logic [NUM_STEPS*ADR_W-1:0]  u_adr,
  input  logic [NUM_STEPS*DATA_W-1:0] u_in,
  input  logic [NUM_STEPS-1:0]        u_r,
  input  logic [NUM_STEPS-1:0]        u_w,
  output logic [ADR_W-1:0]            mem_adr,
  output logic [DATA_W-1:0]           mem_in,
  output logic                        mem_r,
  output logic                        mem_w,
  output logic                        error
);

  localparam int IDX_W = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;

  if ((2 ** TURN_W) < ROUNDS) begin : g_bad_turn_w
    $error("TURN_W is too narrow to count ROUNDS");
  end
  if ((TIMEOUT < 1) || (TIMEOUT > 256)) begin : g_bad_timeout
    $error("TIMEOUT must fit the 8-bit watchdog counter");
  end

  typedef enum logic [1:0] {StIdle, StStart, StWait, StDone} state_e;

  state_e                 state_q;
  logic [IDX_W-1:0]       k_q;
  logic [NUM_STEPS-1:0]   mask_q;

  logic                   higher_found;
  logic [IDX_W-1:0]       higher_idx;
  logic [IDX_W-1:0]       first_idx;
  logic [IDX_W-1:0]       go_idx;

  function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_STEPS-1:0] m);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = NUM_STEPS - 1; i >= 0; i--) begin
      if (m[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  // Next enabled unit above the active one, plus the first enabled unit for the
  // wrap into the next round.
  always_comb begin
    higher_found = 1'b0;
    higher_idx   = '0;
    for (int i = NUM_STEPS - 1; i >= 0; i--) begin
      if (mask_q[i] && (i > int'(k_q))) begin
        higher_found = 1'b1;
        higher_idx   = IDX_W'(i);
      end
    end
    first_idx = lowest_set(mask_q);
    go_idx    = lowest_set(step_mask);
  end

`ifdef STEP_SEQ_WATCHDOG_EN
  logic [7:0] wd_q;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      k_q        <= '0;
      mask_q     <= '0;
      turn       <= '0;
      busy       <= 1'b0;
      finished   <= 1'b0;
      step_start <= '0;
`ifdef STEP_SEQ_WATCHDOG_EN
      wd_q       <= '0;
      error      <= 1'b0;
`endif
    end else begin
      finished   <= 1'b0;
      step_start <= '0;
      unique case (state_q)
        StIdle: begin
          if (go) begin
            busy <= 1'b1;
            turn <= '0;
`ifdef STEP_SEQ_WATCHDOG_EN
            error <= 1'b0;
`endif
            if (step_mask != '0) begin
              mask_q     <= step_mask;
              k_q        <= go_idx;
              step_start <= NUM_STEPS'(1) << go_idx;
              state_q    <= StStart;
            end else begin
              finished <= 1'b1;
              state_q  <= StDone;
            end
          end
        end
        StStart: begin
`ifdef STEP_SEQ_WATCHDOG_EN
          wd_q    <= '0;
`endif
          state_q <= StWait;
        end
        StWait: begin
          if (step_done[k_q]) begin
            if (higher_found) begin
              k_q        <= higher_idx;
              step_start <= NUM_STEPS'(1) << higher_idx;
              state_q    <= StStart;
            end else if (turn < TURN_W'(ROUNDS - 1)) begin
              turn       <= turn + 1'b1;
              k_q        <= first_idx;
              step_start <= NUM_STEPS'(1) << first_idx;
              state_q    <= StStart;
            end else begin
              finished <= 1'b1;
              state_q  <= StDone;
            end
`ifdef STEP_SEQ_WATCHDOG_EN
          end else if (wd_q == 8'(TIMEOUT - 1)) begin
            error    <= 1'b1;
            finished <= 1'b1;
            state_q  <= StDone;
          end else begin
            wd_q <= wd_q + 1'b1;
`endif
          end
        end
        StDone: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifndef STEP_SEQ_WATCHDOG_EN
  assign error = 1'b0;
`endif

  assign last_round = (turn == TURN_W'(ROUNDS - 1));

  // Shared port follows the active unit only while a step is in flight.
  always_comb begin
    mem_adr = '0;
    mem_in  = '0;
    mem_r   = 1'b0;
    mem_w   = 1'b0;
    if ((state_q == StStart) || (state_q == StWait)) begin
      mem_adr = u_adr[int'(k_q)*ADR_W +: ADR_W];
      mem_in  = u_in[int'(k_q)*DATA_W +: DATA_W];
      mem_r   = u_r[k_q];
      mem_w   = u_w[k_q];
    end
  end

endmodule

// File: tb/tb_step_sequencer_arb.sv
// Self-checking bench for step_sequencer_arb. Expected start pulses (unit, turn)
// are queued when a run is launched and popped as the DUT emits step_start.
module tb_step_sequencer_arb;

  localparam int NumSteps = 5;
  localparam int AdrW     = 6;
  localparam int DataW    = 25;
  localparam int Rounds   = 24;
  localparam int TurnW    = 5;
  localparam int Timeout  = 10;

  logic                       clock = 1'b0;
  logic                       reset = 1'b1;
  logic                       go = 1'b0;
  logic [NumSteps-1:0]        step_mask = '0;
  logic                       busy, finished, last_round, mem_r, mem_w, error;
  logic [TurnW-1:0]           turn;
  logic [NumSteps-1:0]        step_start, step_done;
  logic [NumSteps*AdrW-1:0]   u_adr;
  logic [NumSteps*DataW-1:0]  u_in;
  logic [NumSteps-1:0]        u_r, u_w;
  logic [AdrW-1:0]            mem_adr;
  logic [DataW-1:0]           mem_in;

  logic [NumSteps-1:0]        model_done = '0;
  logic [NumSteps-1:0]        man_done = '0;
  logic                       auto_done = 1'b1;

  int n_checks = 0;
  int n_errors = 0;
  int sb_q[$];
  int cnt[NumSteps];
  int dly = 1;
  int busy_cycles = 0;
  int fin_cnt = 0;
  int exp_final_turn = 0;
  int exp_error = 0;
  int cyc = 0;
  int start_cyc = 0;
  int fin_cyc = 0;

  assign step_done = auto_done ? model_done : man_done;

  step_sequencer_arb #(
    .NUM_STEPS (NumSteps),
    .ADR_W     (AdrW),
    .DATA_W    (DataW),
    .ROUNDS    (Rounds),
    .TURN_W    (TurnW),
    .TIMEOUT   (Timeout)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .go         (go),
    .step_mask  (step_mask),
    .busy       (busy),
    .finished   (finished),
    .turn       (turn),
    .last_round (last_round),
    .step_start (step_start),
    .step_done  (step_done),
    .u_adr      (u_adr),
    .u_in       (u_in),
    .u_r        (u_r),
    .u_w        (u_w),
    .mem_adr    (mem_adr),
    .mem_in     (mem_in),
    .mem_r      (mem_r),
    .mem_w      (mem_w),
    .error      (error)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor and unit model: unit k raises done d cycles after its start pulse.
  always @(negedge clock) begin
    int e;
    logic [NumSteps-1:0] oh;
    cyc++;
    if (reset) begin
      for (int k = 0; k < NumSteps; k++) cnt[k] = 0;
      model_done = '0;
    end else begin
      if (busy) busy_cycles++;
      if (finished) begin
        fin_cnt++;
        fin_cyc = cyc;
        check("fin_turn", 64'(turn), 64'(exp_final_turn));
        check("fin_last_round", 64'(last_round), 64'(exp_final_turn == Rounds - 1));
        check("fin_busy", 64'(busy), 64'(1));
        check("fin_error", 64'(error), 64'(exp_error));
        check("fin_mem_idle", 64'({mem_r, mem_w, mem_adr, mem_in}), 64'(0));
      end
      if (step_start != '0) begin
        start_cyc = cyc;
        if (sb_q.size() == 0) begin
          check("start_unexpected", 64'(step_start), 64'(0));
        end else begin
          e = sb_q.pop_front();
          oh = '0;
          oh[e / 256] = 1'b1;
          check("start_unit", 64'(step_start), 64'(oh));
          check("start_turn", 64'(turn), 64'(e % 256));
          check("start_mem_adr", 64'(mem_adr), 64'(u_adr[(e / 256)*AdrW +: AdrW]));
        end
      end
      for (int k = 0; k < NumSteps; k++) begin
        if (step_start[k]) cnt[k] = dly + 1;
        else if (cnt[k] > 0) cnt[k]--;
        model_done[k] = (cnt[k] == 1);
      end
    end
  end

  task automatic start_run(input logic [NumSteps-1:0] mask, input int d);
    for (int r = 0; r < Rounds; r++) begin
      for (int k = 0; k < NumSteps; k++) begin
        if (mask[k]) sb_q.push_back(k * 256 + r);
      end
    end
    exp_final_turn = (mask == '0) ? 0 : Rounds - 1;
    dly = d;
    busy_cycles = 0;
    step_mask = mask;
    go = 1'b1;
    @(posedge clock);
    #1 go = 1'b0;
  endtask

  task automatic wait_finish(input int exp_cycles);
    int f0;
    int n;
    f0 = fin_cnt;
    n = 0;
    while (fin_cnt == f0 && n < 5000) begin
      @(posedge clock);
      n++;
    end
    #1;
    check("finish_in_time", 64'(n < 5000), 64'(1));
    if (exp_cycles >= 0) check("busy_cycles", 64'(busy_cycles), 64'(exp_cycles));
    check("queue_drained", 64'(sb_q.size()), 64'(0));
    check("idle_after_done", 64'({busy, finished}), 64'(0));
  endtask

  initial begin
    int n;
    for (int k = 0; k < NumSteps; k++) begin
      u_adr[k*AdrW +: AdrW]   = AdrW'(k * 9 + 2);
      u_in[k*DataW +: DataW]  = DataW'(k * 3001 + 17);
    end
    u_r = 5'b00101;
    u_w = 5'b10010;

    // Reset values
    #3;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_finished", 64'(finished), 64'(0));
    check("rst_step_start", 64'(step_start), 64'(0));
    check("rst_turn", 64'(turn), 64'(0));
    check("rst_error", 64'(error), 64'(0));
    check("rst_mem", 64'({mem_r, mem_w, mem_adr, mem_in}), 64'(0));
    #9 reset = 1'b0;
    @(posedge clock);
    #1;
    repeat (3) @(posedge clock);
    #1 check("idle_no_go", 64'(busy), 64'(0));

    // All units, done 3 cycles after start
    start_run(5'b11111, 3);
    wait_finish(Rounds * 5 * 4 + 1);

    // Sparse mask; a go and new mask mid-run must be ignored
    start_run(5'b10010, 2);
    repeat (10) @(posedge clock);
    #1 begin step_mask = 5'b11111; go = 1'b1; end
    @(posedge clock);
    #1 go = 1'b0;
    wait_finish(Rounds * 2 * 3 + 1);
    repeat (3) @(posedge clock);
    #1 check("go_not_queued", 64'(busy), 64'(0));

    // Empty mask: a single DONE cycle
    start_run(5'b00000, 1);
    wait_finish(1);

    // Arbitration: unit 2 active, unit 3 also requesting and glitching done
    auto_done = 1'b0;
    man_done = '0;
    start_run(5'b00100, 1);
    @(posedge clock);
    #1;
    u_adr[2*AdrW +: AdrW] = 6'h15;
    u_w = 5'b01100;
    man_done = 5'b01000;
    #1;
    check("arb_mem_adr", 64'(mem_adr), 64'(6'h15));
    check("arb_mem_w", 64'(mem_w), 64'(1));
    check("arb_mem_r", 64'(mem_r), 64'(1));
    check("arb_mem_in", 64'(mem_in), 64'(u_in[2*DataW +: DataW]));
    @(posedge clock);
    #1 man_done = '0;
    check("glitch_no_start", 64'(step_start), 64'(0));
    @(posedge clock);
    #1 check("glitch_turn", 64'(turn), 64'(0));
    check("glitch_busy", 64'(busy), 64'(1));
    man_done = 5'b00100;
    @(posedge clock);
    #1 man_done = '0;
    auto_done = 1'b1;
    u_adr[2*AdrW +: AdrW] = AdrW'(2 * 9 + 2);
    u_w = 5'b10010;
    wait_finish(-1);

`ifdef STEP_SEQ_WATCHDOG_EN
    // Unit 1 never reports done
    auto_done = 1'b0;
    man_done = '0;
    sb_q.push_back(1 * 256 + 0);
    exp_final_turn = 0;
    exp_error = 1;
    busy_cycles = 0;
    step_mask = 5'b00010;
    go = 1'b1;
    @(posedge clock);
    #1 go = 1'b0;
    wait_finish(Timeout + 2);
    check("wd_latency", 64'(fin_cyc - start_cyc), 64'(Timeout + 1));
    check("wd_error_sticky", 64'(error), 64'(1));
    exp_error = 0;
    auto_done = 1'b1;
    start_run(5'b00000, 1);
    check("wd_error_cleared", 64'(error), 64'(0));
    wait_finish(1);
`endif

    // Reset during round 7
    start_run(5'b11111, 3);
    n = 0;
    while (!(turn == TurnW'(7) && step_start[0]) && n < 2000) begin
      @(posedge clock);
      #1 n++;
    end
    check("reach_round7", 64'(n < 2000), 64'(1));
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_outputs", 64'({finished, step_start, error}), 64'(0));
    check("mid_rst_turn", 64'(turn), 64'(0));
    check("mid_rst_mem", 64'({mem_r, mem_w, mem_adr, mem_in}), 64'(0));
    sb_q.delete();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    start_run(5'b00001, 1);
    wait_finish(Rounds * 1 * 2 + 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/step_sequencer_arb.md
Name: step_sequencer_arb

Overview:
- Parametrised successor to the fixed 5-unit Keccak datapath sharing scheme.
- Owns the round/step schedule and drives start to each step unit in turn for ROUNDS rounds.
- Arbitrates the single shared state-memory port to whichever unit is active, replacing the external sel25/sel64 selects and counter24.
- Sits between the top-level controller (go/finished) and the step units plus memory.

Parameters:
- NUM_STEPS, 5, number of step units sequenced per round (unit 0 runs first).
- ADR_W, 6, shared memory address width.
- DATA_W, 25, shared memory write-data width.
- ROUNDS, 24, rounds per run.
- TURN_W, 5, round-index width; must satisfy 2**TURN_W >= ROUNDS.
- TIMEOUT, 255, watchdog limit in cycles (used only with the optional feature).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- go  in  1  run request; sampled only in IDLE.
- step_mask  in  NUM_STEPS  bit k=1 enables unit k; sampled at go.
- busy  out  1  high from the cycle after go is accepted through the DONE cycle.
- finished  out  1  one-cycle pulse in the DONE state.
- turn  out  TURN_W  current round index.
- last_round  out  1  turn==ROUNDS-1.
- step_start  out  NUM_STEPS  one-hot start pulse to the active unit.
- step_done  in  NUM_STEPS  done from each unit.
- u_adr  in  NUM_STEPS*ADR_W  per-unit address; unit k occupies slice [k*ADR_W +: ADR_W].
- u_in  in  NUM_STEPS*DATA_W  per-unit write data.
- u_r  in  NUM_STEPS  per-unit read strobe.
- u_w  in  NUM_STEPS  per-unit write strobe.
- mem_adr  out  ADR_W  shared memory address.
- mem_in  out  DATA_W  shared memory write data.
- mem_r  out  1  shared memory read strobe.
- mem_w  out  1  shared memory write strobe.
- error  out  1  watchdog flag (optional feature only); otherwise tied 0.

Behaviour:
- Reset values: state=IDLE; busy, finished, step_start, turn, error all 0; memory outputs 0.
- Reset mid-run returns to IDLE immediately and drops all outputs.
- States are IDLE, START, WAIT, DONE. The registered step index is k.
- IDLE:
  - On go=1 with step_mask!=0: latch the mask; k = lowest set bit; turn = 0; go to START.
  - On go=1 with step_mask==0: go to DONE.
  - Otherwise stay in IDLE.
- START (one cycle): step_start[k]=1 and all other bits 0. Go to WAIT.
- WAIT:
  - Hold until step_done[k]=1.
  - Done from non-active units is ignored.
  - A done asserted during START is ignored; the unit must hold done, or re-assert it, in WAIT.
- On step_done[k]=1 in WAIT, choose the next step:
  - If a higher unmasked index exists, k takes that index and the next state is START.
  - Otherwise, if turn<ROUNDS-1, turn increments, k takes the lowest unmasked index, and the next state is START.
  - Otherwise the next state is DONE.
- DONE (one cycle): finished=1 and busy=1. Go to IDLE.
- go asserted while busy is ignored and is not queued.
- Memory arbitration is combinational:
  - In START and WAIT, the mem_* outputs equal unit k's slices.
  - In IDLE and DONE, mem_r=mem_w=0 and mem_adr=mem_in=0.
- Cycle count for a run with M unmasked units, each finishing d cycles after its start: ROUNDS*M*(1+d)+1 cycles from the first busy cycle through DONE.
- last_round is combinational from turn.

Optional Feature:
- Macro: STEP_SEQ_WATCHDOG_EN.
- With the macro defined:
  - An 8-bit cycle counter clears on START and counts in WAIT.
  - If it reaches TIMEOUT without the active done, error is set (sticky) and the state goes to DONE; finished still pulses.
  - error clears only on reset or on the next accepted go.
- Without the macro: no counter, error is tied 0, and WAIT waits indefinitely.

Test Plan:
- ROUNDS=24, mask=5'b11111, every unit asserts done 3 cycles after its start -> 120 start pulses in order 0..4 repeating, turn steps 0..23, finished after 24*5*4+1=481 busy cycles.
- mask=5'b10010 -> only units 1 and 4 are started each round; units 0, 2, 3 never see step_start; finished after 24*2*(1+d)+1 cycles.
- mask=0 with go -> busy for exactly one cycle with finished=1, turn stays 0, no step_start.
- Unit 2 active driving u_adr=6'h15, u_w=1, while unit 3 drives u_w=1 -> mem_adr=6'h15 and mem_w=1 taken from unit 2 only; a step_done[3] glitch is ignored.
- Assert reset during round 7 WAIT -> all outputs 0 asynchronously; next go restarts from turn=0, unit 0.
- With STEP_SEQ_WATCHDOG_EN and TIMEOUT=10, unit 1 never asserts done -> error=1 and finished pulses 11 cycles after unit 1's start; a following go clears error.
